// File: rtl/led_meter_ctrl_if.sv
// led_meter_ctrl_if: stereo sample stream from the FIR output stage
interface led_meter_ctrl_if;
  logic        vld;
  logic [15:0] aud_out_lft;
  logic [15:0] aud_out_rght;
  modport master (output vld, aud_out_lft, aud_out_rght);
  modport slave  (input  vld, aud_out_lft, aud_out_rght);
endinterface

// File: rtl/led_meter_ctrl.sv
// led_meter_ctrl: peak-hold stereo LED bar graph with decay and lamp-test sweep
module led_meter_ctrl #(
  parameter int DECAY_CYC  = 50000,
  parameter int HOLD_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  led_meter_ctrl_if.slave        aud,
  input  logic                   lamp_test,
  output logic [7:0]             LED,
  output logic                   busy
);
  localparam int             CW      = $clog2(DECAY_CYC);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DECAY_CYC - 1);
  localparam logic [3:0]     HOLD    = 4'(HOLD_TICKS);
  typedef enum logic {RUN, TEST} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0][2:0] peak_q, peak_d, lvl;
  logic [1:0][3:0] hold_q, hold_d;
  logic [7:0]      led_q, led_d;
  logic            busy_q, busy_d, tick, run, start, done;
  function automatic logic [14:0] mag(input logic [15:0] x);
    return x == 16'h8000 ? 15'h7FFF : 15'(x[15] ? -x : x);
  endfunction
  function automatic logic [2:0] level(input logic [14:0] m);
    return m >= 15'd8192 ? 3'd4 : m >= 15'd1024 ? 3'd3 : m >= 15'd128 ? 3'd2 : m >= 15'd16 ? 3'd1 : 3'd0;
  endfunction
  function automatic logic [3:0] therm(input logic [2:0] p);
    return 4'((5'd1 << p) - 5'd1);
  endfunction
  assign tick   = cnt_q == CNT_MAX;
  assign run    = state_q == RUN;
  assign start  = run && lamp_test;
  assign done   = !run && tick && led_q == 8'h80;
  assign lvl[1] = level(mag(aud.aud_out_lft));
  assign lvl[0] = level(mag(aud.aud_out_rght));
  assign LED    = led_q;
  assign busy   = busy_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  always_comb state_d = start ? TEST : done ? RUN : state_q;
  always_comb begin
    cnt_d  = (start || tick) ? '0 : cnt_q + CW'(1);
    peak_d = peak_q;
    hold_d = hold_q;
    for (int i = 0; i < 2; i++)
      if (run && !lamp_test) begin
        if (aud.vld && lvl[i] > peak_q[i]) begin
          peak_d[i] = lvl[i];
          hold_d[i] = HOLD;
        end else if (aud.vld && lvl[i] == peak_q[i] && peak_q[i] != 3'd0)
          hold_d[i] = HOLD;
        else if (tick && hold_q[i] != 4'd0)
          hold_d[i] = hold_q[i] - 4'd1;
        else if (tick && peak_q[i] != 3'd0)
          peak_d[i] = peak_q[i] - 3'd1;
      end
    if (done) begin
      peak_d = '0;
      hold_d = '0;
    end
    led_d  = start ? 8'h01 : run ? {therm(peak_d[1]), therm(peak_d[0])} : tick ? led_q << 1 : led_q;
    busy_d = start || (!run && !done);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      peak_q <= '0;
      hold_q <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_led_meter_ctrl.sv
// tb_led_meter_ctrl: directed scoreboard bench for led_meter_ctrl (DECAY_CYC=4, HOLD_TICKS=2)
module tb_led_meter_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lamp_test = 1'b0;
  logic [7:0] LED;
  logic       busy;
  led_meter_ctrl_if aud();
  led_meter_ctrl #(.DECAY_CYC(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .aud(aud), .lamp_test(lamp_test), .LED(LED), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {string tag; logic [7:0] led; logic busy;} exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  function automatic logic [3:0] th(int n);
    case (n)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0011;
      3: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction
  task automatic push(string tag, logic [7:0] led, logic b);
    exp_t e;
    e.tag = tag;
    e.led = led;
    e.busy = b;
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      assert ({LED, busy} === {e.led, e.busy}) else begin
        miscompares++;
        $error("FAIL %s: got LED=%h busy=%b, want LED=%h busy=%b", e.tag, LED, busy, e.led, e.busy);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic cycle(string tag, logic [7:0] led, logic b);
    push(tag, led, b);
    step();
    check();
  endtask
  task automatic quiet();
    aud.vld = 1'b0;
    aud.aud_out_lft = 16'h0000;
    aud.aud_out_rght = 16'h0000;
    lamp_test = 1'b0;
  endtask
  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1 push(tag, 8'h00, 1'b0);
    check();
    #1 rst = 1'b0;
    quiet();
  endtask
  task automatic phase_after_release(string tag);
    aud.vld = 1'b1;
    aud.aud_out_lft = 16'h4000;
    cycle({tag, "_cap"}, 8'hF0, 1'b0);
    aud.vld = 1'b0;
    idle(9);
    cycle({tag, "_e11"}, 8'hF0, 1'b0);
    cycle({tag, "_e12"}, 8'h70, 1'b0);
  endtask
  int vals[8] = '{15, 16, 127, 128, 1023, 1024, 8191, 8192};
  logic [3:0] want[8] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
  initial begin
    quiet();
    #2 push("reset", 8'h00, 1'b0);
    check();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) begin
        do_reset();
        aud.vld = 1'b1;
        aud.aud_out_rght = s != 0 ? 16'(-vals[i]) : 16'(vals[i]);
        cycle($sformatf("thr_%s%0d", s != 0 ? "neg" : "pos", vals[i]), {4'h0, want[i]}, 1'b0);
        aud.vld = 1'b0;
      end
    do_reset();
    aud.vld = 1'b1;
    aud.aud_out_lft = 16'h8000;
    aud.aud_out_rght = 16'hFFEF;
    cycle("sat_split", 8'hF1, 1'b0);
    do_reset();
    aud.vld = 1'b1;
    aud.aud_out_lft = 16'h4000;
    cycle("decay_cap", 8'hF0, 1'b0);
    aud.vld = 1'b0;
    for (int k = 2; k <= 24; k++)
      cycle($sformatf("decay_e%0d", k), {th(k < 12 ? 4 : 4 - (k - 8) / 4), 4'h0}, 1'b0);
    do_reset();
    aud.vld = 1'b1;
    aud.aud_out_rght = 16'd1024;
    cycle("rt_cap", 8'h07, 1'b0);
    aud.vld = 1'b0;
    idle(10);
    aud.vld = 1'b1;
    cycle("rt_collide", 8'h07, 1'b0);
    aud.vld = 1'b0;
    idle(10);
    cycle("rt_held", 8'h07, 1'b0);
    cycle("rt_decay", 8'h03, 1'b0);
    idle(3);
    aud.vld = 1'b1;
    aud.aud_out_rght = 16'd16;
    cycle("low_vld_tick", 8'h01, 1'b0);
    aud.vld = 1'b0;
    do_reset();
    aud.vld = 1'b1;
    aud.aud_out_lft = 16'h8000;
    cycle("lt_prepeak", 8'hF0, 1'b0);
    lamp_test = 1'b1;
    cycle("lt_start", 8'h01, 1'b1);
    lamp_test = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      aud.vld = (j % 2) == 0;
      lamp_test = j == 10;
      cycle($sformatf("sweep%0d", j), j < 32 ? 8'(8'h01 << (j / 4)) : 8'h00, j < 32);
    end
    quiet();
    cycle("lt_cleared", 8'h00, 1'b0);
    do_reset();
    lamp_test = 1'b1;
    cycle("ar_sweep_start", 8'h01, 1'b1);
    lamp_test = 1'b0;
    idle(9);
    async_reset("ar_mid_sweep");
    phase_after_release("ar_sweep");
    do_reset();
    aud.vld = 1'b1;
    aud.aud_out_lft = 16'h4000;
    cycle("ar_decay_cap", 8'hF0, 1'b0);
    aud.vld = 1'b0;
    idle(11);
    cycle("ar_decay_e13", 8'h70, 1'b0);
    async_reset("ar_mid_decay");
    phase_after_release("ar_decay");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
